// File: rtl/mux_n_1_stream_pkg.sv
// Shared definitions for the N:1 stream multiplexer.
//   state_e     : packet-lock FSM encoding (ST_IDLE / ST_LOCKED)
//   MODE_RR     : round-robin arbitration across channels
//   MODE_FIXED  : channel chosen by the external sel input
//   clog2_min1  : ceil(log2(n)), never less than 1, for channel-id widths
package mux_n_1_stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_n_1_stream_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      in   N      per-channel request
//   ptr      in   SEL_W  last channel served; search starts at ptr+1 (mod N)
//   grant    out  N      one-hot grant, zero when no request
//   grant_id out  SEL_W  index of the granted channel (0 when none)
module mux_n_1_stream_rr_arbiter
  import mux_n_1_stream_pkg::*;
#(
  parameter int N     = 16,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_id
);

  logic [SEL_W:0]   cand;
  logic [SEL_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after ptr is the last one written and therefore wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    cand     = '0;
    idx      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(N)) cand = cand - (SEL_W+1)'(N);
      idx = cand[SEL_W-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_stream.sv
// N:1 valid/ready stream multiplexer with packet locking and one
// registered output stage.
//   clk, rst                  clock, synchronous active-high reset
//   in_data/in_valid/in_last  N input channels (channel i at [i*WIDTH +: WIDTH])
//   in_ready                  per-channel ready, one-hot or zero
//   sel                       channel select (MODE_FIXED only)
//   out_data/out_last/out_sel registered beat and its source channel
//   out_valid/out_ready       output handshake
//
// state     | meaning
// ST_IDLE   | between packets; grant from arbiter (RR) or sel (FIXED)
// ST_LOCKED | mid-packet; only lock_ch may transfer until its last beat
module mux_n_1_stream
  import mux_n_1_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 16,
  parameter int SEL_W = clog2_min1(N),
  parameter int MODE  = MODE_RR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     rr_grant;
  logic [SEL_W-1:0] rr_id;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_id;
  logic             can_load;
  logic             accept;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  mux_n_1_stream_rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr_q),
    .grant    (rr_grant),
    .grant_id (rr_id)
  );

  always_comb begin
    grant    = '0;
    grant_id = '0;
    if (state_q == ST_LOCKED) begin
      if (in_valid[lock_ch_q]) begin
        grant[lock_ch_q] = 1'b1;
        grant_id         = lock_ch_q;
      end
    end else if (MODE == MODE_FIXED) begin
      // Out-of-range selects (possible when N is not a power of two) grant nothing.
      if ({1'b0, sel} < (SEL_W+1)'(N)) begin
        if (in_valid[sel]) begin
          grant[sel] = 1'b1;
          grant_id   = sel;
        end
      end
    end else begin
      grant    = rr_grant;
      grant_id = rr_id;
    end
  end

  assign can_load  = !out_valid_q || out_ready;
  assign accept    = can_load && (|grant);
  assign in_ready  = can_load ? grant : '0;
  assign beat_data = in_data[int'(grant_id)*WIDTH +: WIDTH];
  assign beat_last = in_last[grant_id];

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_last_d  = beat_last;
      out_sel_d   = grant_id;
      if (beat_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = grant_id;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant_id;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // rr_ptr resets to N-1 so channel 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(N-1);
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Three instances share one stimulus: 16-ch fixed select, 16-ch round-robin,
// 12-ch fixed select (lower 12 channels). A behavioural model per instance is
// checked every cycle; directed steps add hand-computed literal checks.
module tb_mux_n_1_stream;

  logic         clk;
  logic         rst;
  logic [255:0] in_data;
  logic [15:0]  in_valid;
  logic [15:0]  in_last;
  logic [3:0]   sel;
  logic         out_ready;

  logic [15:0] f16_rdy, r16_rdy;
  logic [11:0] f12_rdy;
  logic [15:0] f16_data, r16_data, f12_data;
  logic        f16_last, r16_last, f12_last;
  logic [3:0]  f16_sel, r16_sel, f12_sel;
  logic        f16_vld, r16_vld, f12_vld;

  int tests = 0;
  int fails = 0;

  mux_n_1_stream #(.WIDTH(16), .N(16), .MODE(1)) u_f16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(f16_rdy), .sel(sel), .out_data(f16_data), .out_last(f16_last),
    .out_sel(f16_sel), .out_valid(f16_vld), .out_ready(out_ready));

  mux_n_1_stream #(.WIDTH(16), .N(16), .MODE(0)) u_r16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(r16_rdy), .sel(sel), .out_data(r16_data), .out_last(r16_last),
    .out_sel(r16_sel), .out_valid(r16_vld), .out_ready(out_ready));

  mux_n_1_stream #(.WIDTH(16), .N(12), .MODE(1)) u_f12 (
    .clk(clk), .rst(rst), .in_data(in_data[191:0]), .in_valid(in_valid[11:0]),
    .in_last(in_last[11:0]), .in_ready(f12_rdy), .sel(sel), .out_data(f12_data),
    .out_last(f12_last), .out_sel(f12_sel), .out_valid(f12_vld), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mn   [3] = '{16, 16, 12};
  int mmode[3] = '{1, 0, 1};
  int m_valid[3], m_data[3], m_last[3], m_sel[3];
  int m_locked[3], m_lock[3], m_ptr[3];
  bit armed = 0;

  logic [15:0] o_data[3], o_rdy[3];
  logic        o_last[3], o_vld[3];
  logic [3:0]  o_sel[3];
  assign o_data[0] = f16_data; assign o_data[1] = r16_data; assign o_data[2] = f12_data;
  assign o_last[0] = f16_last; assign o_last[1] = r16_last; assign o_last[2] = f12_last;
  assign o_sel[0]  = f16_sel;  assign o_sel[1]  = r16_sel;  assign o_sel[2]  = f12_sel;
  assign o_vld[0]  = f16_vld;  assign o_vld[1]  = r16_vld;  assign o_vld[2]  = f12_vld;
  assign o_rdy[0]  = f16_rdy;  assign o_rdy[1]  = r16_rdy;  assign o_rdy[2]  = {4'h0, f12_rdy};

  // Channel that may transfer this cycle, -1 for none.
  function automatic int model_grant(input int d);
    int n, c;
    n = mn[d];
    if (m_locked[d] != 0) return in_valid[m_lock[d]] ? m_lock[d] : -1;
    if (mmode[d] == 1) return (int'(sel) < n && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= n; k++) begin
      c = (m_ptr[d] + k) % n;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int g;
    bit can;
    logic [15:0] exp_rdy;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        g   = model_grant(d);
        can = (m_valid[d] == 0) || out_ready;
        exp_rdy = (can && g >= 0) ? (16'h1 << g) : 16'h0;
        if (armed) begin
          check($sformatf("m%0d_valid", d), 32'(o_vld[d]),  32'(m_valid[d]));
          check($sformatf("m%0d_data", d),  32'(o_data[d]), 32'(m_data[d]));
          check($sformatf("m%0d_last", d),  32'(o_last[d]), 32'(m_last[d]));
          check($sformatf("m%0d_sel", d),   32'(o_sel[d]),  32'(m_sel[d]));
          check($sformatf("m%0d_ready", d), 32'(o_rdy[d]),  32'(exp_rdy));
        end
        if (rst) begin
          m_valid[d] = 0; m_data[d] = 0; m_last[d] = 0; m_sel[d] = 0;
          m_locked[d] = 0; m_lock[d] = 0; m_ptr[d] = mn[d] - 1;
        end else if (can && g >= 0) begin
          m_valid[d] = 1;
          m_data[d]  = int'(in_data[g*16 +: 16]);
          m_last[d]  = int'(in_last[g]);
          m_sel[d]   = g;
          if (in_last[g]) begin m_locked[d] = 0; m_ptr[d] = g; end
          else            begin m_locked[d] = 1; m_lock[d] = g; end
        end else if (out_ready) begin
          m_valid[d] = 0;
        end
      end
      if (rst) armed = 1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; sel = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) in_data[i*16 +: 16] = 16'(i + 1);
    step(); step();
    check("rst_valid_f16", 32'(f16_vld), 32'd0);
    check("rst_data_r16",  32'(r16_data), 32'd0);
    check("rst_sel_f12",   32'(f12_sel), 32'd0);

    // Fixed sel sweep and round-robin rotation on the same traffic.
    rst = 1'b0; in_valid = 16'hFFFF; in_last = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      sel = 4'(i % 16);
      step();
      check("fix_data", 32'(f16_data), 32'(i % 16 + 1));
      check("fix_sel",  32'(f16_sel),  32'(i % 16));
      check("rr_sel",   32'(r16_sel),  32'(i % 16));
      if (i == 13) begin
        check("n12_sel13_valid", 32'(f12_vld), 32'd0);
        check("n12_sel13_ready", 32'(f12_rdy), 32'd0);
      end
    end

    // sel points at an idle channel.
    in_valid = 16'h7FFF; sel = 4'd15;
    step();
    check("sel15_idle_valid", 32'(f16_vld), 32'd0);
    check("sel15_idle_ready", 32'(f16_rdy), 32'd0);

    in_valid = '0; step(); step();

    // 4-beat packet on ch3 while ch5 also requests; sel moves mid-packet.
    sel = 4'd3; in_last = '0; in_valid = 16'h0008; in_data[3*16 +: 16] = 16'h0101;
    step();
    check("pkt_b1_sel",  32'(r16_sel),  32'd3);
    check("pkt_b1_data", 32'(r16_data), 32'h0101);
    in_valid = 16'h0028; sel = 4'd5;
    for (int b = 2; b <= 4; b++) begin
      in_data[3*16 +: 16] = 16'(16'h0100 + b);
      if (b == 4) in_last = 16'h0028;
      step();
      check("pkt_rr_sel",  32'(r16_sel),  32'd3);
      check("pkt_rr_data", 32'(r16_data), 32'(16'h0100 + b));
      check("pkt_fix_sel", 32'(f16_sel),  32'd3);
    end
    in_valid = 16'h0020; in_last = 16'hFFFF;
    step();
    check("after_pkt_sel",  32'(r16_sel),  32'd5);
    check("after_pkt_data", 32'(r16_data), 32'd6);

    // Backpressure: held output, no ready anywhere, then resume without loss.
    out_ready = 1'b0; in_valid = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_data",  32'(r16_data), 32'd6);
      check("bp_valid", 32'(r16_vld),  32'd1);
      check("bp_ready", 32'(r16_rdy),  32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_rel_sel",  32'(r16_sel),  32'd6);
    check("bp_rel_data", 32'(r16_data), 32'd7);
    step();
    check("bp_next_sel", 32'(r16_sel), 32'd7);

    // Reset while locked mid-packet.
    in_valid = 16'h0200; in_last = '0;
    step();
    check("lock9_sel", 32'(r16_sel), 32'd9);
    rst = 1'b1; in_valid = 16'hFFFF; in_last = 16'hFFFF;
    step();
    check("rst_mid_valid_r16", 32'(r16_vld), 32'd0);
    check("rst_mid_valid_f16", 32'(f16_vld), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_rr_sel",  32'(r16_sel),  32'd0);
    check("post_rst_rr_data", 32'(r16_data), 32'd1);
    check("post_rst_fix_sel", 32'(f16_sel),  32'd5);
    in_valid = '0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
